// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out handshake bundle for serial_word_receiver.
// The master side drives the serial stream and ParReady; the slave side is the receiver.
interface serial_word_receiver_if #(
  parameter int WORD_W = 8
);
  logic              SerIn;
  logic              SerInValid;
  logic              ParReady;
  logic [WORD_W-1:0] ParOut;
  logic              ParValid;

  modport master (output SerIn, SerInValid, ParReady, input ParOut, ParValid);
  modport slave  (input SerIn, SerInValid, ParReady, output ParOut, ParValid);
endinterface

// File: rtl/serial_word_receiver.sv
// Deserializes valid bursts into WORD_W-bit words, buffers them in a fall-through FIFO,
// shows occupancy on a 7-segment digit and keeps sticky frame/overflow flags.
//
// state  | meaning
// S_IDLE | no burst in progress, bit counter is 0
// S_RECV | inside a valid burst, assembling words back-to-back
module serial_word_receiver #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_receiver_if.slave bus,
  input  logic                 ClrErr,
  output logic [3:0]           FifoCount,
  output logic                 FrameErr,
  output logic                 Overflow,
  output logic [6:0]           SSD
);
  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_sr, w_sr_nxt;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [3:0]        r_count;
  logic              r_frame_err, r_overflow;
  logic              w_word_done, w_frame_err;
  logic              w_full, w_pop, w_push, w_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.SerInValid)  w_state_nxt = S_RECV;
      S_RECV:  if (!bus.SerInValid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_word_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_RECV: begin
        w_word_done = bus.SerInValid && (r_bit_cnt == CNT_W'(WORD_W - 1));
        w_frame_err = !bus.SerInValid && (r_bit_cnt != '0);
      end
      default: ;
    endcase
  end

  // The completing bit is folded into the pushed word, so the FIFO writes w_sr_nxt.
  assign w_sr_nxt = MSB_FIRST ? {r_sr[WORD_W-2:0], bus.SerIn}
                              : {bus.SerIn, r_sr[WORD_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (bus.SerInValid) begin
      r_sr      <= w_sr_nxt;
      r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
    end else begin
      r_bit_cnt <= '0;
    end
  end

  assign w_full = (r_count == 4'(FIFO_DEPTH));
  assign w_pop  = (r_count != 4'd0) && bus.ParReady;
  assign w_push = w_word_done && (!w_full || w_pop);
  assign w_ovf  = w_word_done && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sr_nxt;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_frame_err) r_frame_err <= 1'b1;
      else if (ClrErr) r_frame_err <= 1'b0;
      if (w_ovf)       r_overflow  <= 1'b1;
      else if (ClrErr) r_overflow  <= 1'b0;
    end
  end

  assign bus.ParOut   = r_mem[r_rd_ptr];
  assign bus.ParValid = (r_count != 4'd0);
  assign FifoCount    = r_count;
  assign FrameErr     = r_frame_err;
  assign Overflow     = r_overflow;

  always_comb begin
    SSD = 7'b1111111;
    case (r_count)
      4'h0: SSD = 7'b1000000;
      4'h1: SSD = 7'b1111001;
      4'h2: SSD = 7'b0100100;
      4'h3: SSD = 7'b0110000;
      4'h4: SSD = 7'b0011001;
      4'h5: SSD = 7'b0010010;
      4'h6: SSD = 7'b0000010;
      4'h7: SSD = 7'b1111000;
      4'h8: SSD = 7'b0000000;
      4'h9: SSD = 7'b0010000;
      4'hA: SSD = 7'b0001000;
      4'hB: SSD = 7'b0000011;
      4'hC: SSD = 7'b1000110;
      4'hD: SSD = 7'b0100001;
      4'hE: SSD = 7'b0000110;
      4'hF: SSD = 7'b0001110;
      default: SSD = 7'b1111111;
    endcase
  end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share one random serial stream;
// a burst-level model predicts words, occupancy and flags, a monitor checks popped words.
module tb_serial_word_receiver;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0, svld = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [3:0] cnt_m, cnt_l;
  logic       fe_m, fe_l, ov_m, ov_l;
  logic [6:0] ssd_m, ssd_l;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WORD_W(W)) bus_m ();
  serial_word_receiver_if #(.WORD_W(W)) bus_l ();

  assign bus_m.SerIn = sin;  assign bus_m.SerInValid = svld;  assign bus_m.ParReady = rdy;
  assign bus_l.SerIn = sin;  assign bus_l.SerInValid = svld;  assign bus_l.ParReady = rdy;

  serial_word_receiver #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m.slave), .ClrErr(clr),
    .FifoCount(cnt_m), .FrameErr(fe_m), .Overflow(ov_m), .SSD(ssd_m));

  serial_word_receiver #(.WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l.slave), .ClrErr(clr),
    .FifoCount(cnt_l), .FrameErr(fe_l), .Overflow(ov_l), .SSD(ssd_l));

  int n_tests = 0;
  int n_fail  = 0;

  int             m_cnt = 0;
  bit             m_fe = 0, m_ov = 0;
  bit             bits[$];
  logic [W-1:0]   sb_m[$];
  logic [W-1:0]   sb_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ssd_ref(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_outputs();
    chk("count_msb", 32'(cnt_m), 32'(m_cnt));
    chk("count_lsb", 32'(cnt_l), 32'(m_cnt));
    chk("valid", 32'(bus_m.ParValid), 32'(m_cnt != 0));
    chk("frame_err", 32'(fe_m), 32'(m_fe));
    chk("frame_err_lsb", 32'(fe_l), 32'(m_fe));
    chk("overflow", 32'(ov_m), 32'(m_ov));
    chk("overflow_lsb", 32'(ov_l), 32'(m_ov));
    chk("ssd", 32'(ssd_m), 32'(ssd_ref(m_cnt)));
    if (m_cnt != 0) begin
      chk("head_msb", 32'(bus_m.ParOut), 32'(sb_m[0]));
      chk("head_lsb", 32'(bus_l.ParOut), 32'(sb_l[0]));
    end
  endtask

  // Called at a falling edge: drive one clock's inputs, advance the model, check after the edge.
  task automatic step(input bit b, input bit v, input bit r, input bit c);
    bit pop, push, set_fe, set_ov;
    logic [W-1:0] wm, wl;
    #1;
    sin = b; svld = v; rdy = r; clr = c;
    pop = (m_cnt != 0) && r;
    push = 0; set_fe = 0; set_ov = 0; wm = '0; wl = '0;
    if (v) begin
      bits.push_back(b);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits[i];
          wl[i]     = bits[i];
        end
        push = 1;
        bits.delete();
      end
    end else if (bits.size() != 0) begin
      set_fe = 1;
      bits.delete();
    end
    if (push && m_cnt == D && !pop) begin
      set_ov = 1;
      push = 0;
    end
    if (push) begin
      sb_m.push_back(wm);
      sb_l.push_back(wl);
    end
    m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    m_fe = set_fe ? 1'b1 : (c ? 1'b0 : m_fe);
    m_ov = set_ov ? 1'b1 : (c ? 1'b0 : m_ov);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0);
  endtask

  // Called at a falling edge; asserts reset asynchronously between edges.
  task automatic do_reset();
    #1;
    rst = 1'b0; svld = 1'b0; rdy = 1'b0; clr = 1'b0;
    m_cnt = 0; m_fe = 0; m_ov = 0;
    bits.delete(); sb_m.delete(); sb_l.delete();
    #1;
    chk("rst_count", 32'(cnt_m), 32'd0);
    chk("rst_valid", 32'(bus_m.ParValid), 32'd0);
    chk("rst_parout", 32'(bus_m.ParOut), 32'd0);
    chk("rst_flags", 32'({fe_m, ov_m}), 32'd0);
    chk("rst_ssd", 32'(ssd_m), 32'(7'b1000000));
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  // Monitor: a word leaves the FIFO on the next rising edge whenever valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus_m.ParValid && rdy) begin
        if (sb_m.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_underflow: got word %0h, expected no word", bus_m.ParOut);
        end else begin
          chk("pop_msb", 32'(bus_m.ParOut), 32'(sb_m.pop_front()));
          chk("pop_lsb", 32'(bus_l.ParOut), 32'(sb_l.pop_front()));
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // single word 1,0,1,1,0,0,1,0
    send_word(8'hB2, 1'b0);
    chk("single_word", 32'(bus_m.ParOut), 32'h0000_00B2);
    chk("single_valid", 32'(bus_m.ParValid), 32'd1);
    chk("single_ssd", 32'(ssd_m), 32'(7'b1111001));
    idle(1, 1'b1);
    idle(1, 1'b0);

    // back-to-back words, then two pops
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    idle(1, 1'b0);
    chk("b2b_count", 32'(cnt_m), 32'd2);
    chk("b2b_head", 32'(bus_m.ParOut), 32'h0000_00A5);
    idle(2, 1'b1);
    chk("b2b_drained", 32'(bus_m.ParValid), 32'd0);

    // partial frame, then a clean word and an error clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("partial_fe", 32'(fe_m), 32'd1);
    chk("partial_count", 32'(cnt_m), 32'd0);
    send_word(8'h5E, 1'b0);
    idle(1, 1'b0);
    chk("after_partial_word", 32'(bus_m.ParOut), 32'h0000_005E);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_fe", 32'(fe_m), 32'd0);

    // LSB-first: bits 1,0,0,0,0,0,0,0
    send_word(8'h80, 1'b0);
    chk("lsb_first", 32'(bus_l.ParOut), 32'h0000_0001);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // overflow: five words into a depth-4 FIFO
    for (int k = 0; k < 5; k++) send_word(8'(8'h11 * (k + 1)), 1'b0);
    idle(1, 1'b0);
    chk("ovf_count", 32'(cnt_m), 32'd4);
    chk("ovf_flag", 32'(ov_m), 32'd1);
    idle(D + 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // full FIFO with a pop on the completing edge accepts the fifth word
    for (int k = 0; k < 4; k++) send_word(8'(8'h21 + k), 1'b0);
    for (int i = W - 1; i >= 1; i--) step(1'(8'hC7 >> i), 1'b1, 1'b0, 1'b0);
    step(1'(8'hC7), 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("full_pop_ovf", 32'(ov_m), 32'd0);
    chk("full_pop_count", 32'(cnt_m), 32'd4);
    idle(D + 1, 1'b1);

    // reset mid-word with a non-empty FIFO
    send_word(8'h99, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(8'h4D, 1'b0);
    chk("post_reset_word", 32'(bus_m.ParOut), 32'h0000_004D);
    idle(2, 1'b1);

    // randomized traffic
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    idle(D + 2, 1'b1);
    chk("final_empty", 32'(sb_m.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
